// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: reverse double-dabble BCD->binary converter, one bit per clk; in: clk, rst_n (sync, active-low), start, bcd_in; out: busy, done (1-cycle pulse), bin_out, err (nibble > 9)
module bcd_to_binary_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);
  localparam int SW = 4*DIGITS + BIN_W;
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  state_t state, state_n;
  logic [SW-1:0] sr, sr_n;
  logic [CW-1:0] cnt;
  logic bad, accept, last;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad = bad | (bcd_in[4*i +: 4] > 4'd9);
    sr_n = sr >> 1;
    for (int i = 0; i < DIGITS; i++)
      sr_n[BIN_W+4*i +: 4] = sr_n[BIN_W+4*i +: 4] >= 4'd8 ? sr_n[BIN_W+4*i +: 4] - 4'd3 : sr_n[BIN_W+4*i +: 4];
    accept = start && state != CONV;
    last = cnt == CW'(BIN_W - 1);
    state_n = accept ? (bad ? DONE : CONV) : state == CONV ? (last ? DONE : CONV) : IDLE;
  end
  assign busy = state == CONV;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      bin_out <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        sr <= bad ? '0 : {bcd_in, {BIN_W{1'b0}}};
        cnt <= '0;
        if (bad) begin
          bin_out <= '0;
          err <= 1'b1;
        end
      end else if (state == CONV) begin
        sr <= sr_n;
        cnt <= cnt + CW'(1);
        if (last) begin
          bin_out <= sr_n[BIN_W-1:0];
          err <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb_bcd_to_binary_seq: scoreboard bench for bcd_to_binary_seq; expected result and done cycle queued at issue, checked by a monitor on each done
module tb_bcd_to_binary_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] bcd_in = '0;
  logic busy, done, err;
  logic [6:0] bin_out;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  logic [39:0] q[$];
  bcd_to_binary_seq #(.DIGITS(2), .BIN_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .bin_out(bin_out), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) check("busy_and_done", 1, 0);
      if (done) begin
        if (q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          logic [39:0] e;
          e = q.pop_front();
          check("bin_out", int'(bin_out), int'(e[6:0]));
          check("err", int'(err), int'(e[7]));
          check("done_cycle", cyc, int'(e[39:8]));
        end
      end
    end
  end
  task automatic send(input logic [7:0] b, input int eb, input bit ee, input int lat);
    start = 1'b1;
    bcd_in = b;
    q.push_back({32'(cyc + 1 + lat), ee, 7'(eb)});
    @(posedge clk); #1;
    start = 1'b0;
    repeat (lat) @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int c0;
    idle(2);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_bin", int'(bin_out), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    idle(1);
    send(8'h42, 42, 0, 7);
    idle(2);
    send(8'h99, 99, 0, 7);
    idle(1);
    send(8'h00, 0, 0, 7);
    idle(1);
    send(8'h10, 10, 0, 7);
    idle(1);
    send(8'h1A, 0, 1, 0);
    idle(1);
    send(8'h05, 5, 0, 7);
    idle(1);
    send(8'hA3, 0, 1, 0);
    send(8'h73, 73, 0, 7);
    idle(1);
    c0 = cyc;
    start = 1'b1;
    bcd_in = 8'h25;
    q.push_back({32'(c0 + 8), 1'b0, 7'd25});
    idle(1);
    bcd_in = 8'h77;
    idle(3);
    bcd_in = 8'h63;
    idle(4);
    check("hold_in_done", int'(done), 1);
    q.push_back({32'(cyc + 8), 1'b0, 7'd63});
    idle(1);
    start = 1'b0;
    bcd_in = 8'h11;
    idle(7);
    idle(1);
    start = 1'b1;
    bcd_in = 8'h50;
    idle(1);
    start = 1'b0;
    idle(2);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_bin", int'(bin_out), 0);
    check("midrst_err", int'(err), 0);
    idle(10);
    send(8'h37, 37, 0, 7);
    idle(1);
    for (int d = 0; d < 100; d++) send({4'(d / 10), 4'(d % 10)}, d, 0, 7);
    idle(3);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
